// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the ALU issue controller: unit/sub-op encodings, FSM states, flag positions.
// Also holds the request-legality and flag-packing helpers used by the top.
package alu_ctrl_pkg;

  localparam logic [1:0] UNIT_ADD   = 2'd0;
  localparam logic [1:0] UNIT_SHIFT = 2'd1;
  localparam logic [1:0] UNIT_LOGIC = 2'd2;
  localparam logic [1:0] UNIT_MUL   = 2'd3;

  localparam logic [3:0] SUB_ADD  = 4'd0;
  localparam logic [3:0] SUB_ADD1 = 4'd1;
  localparam logic [3:0] SUB_SUB  = 4'd2;
  localparam logic [3:0] SUB_SUB1 = 4'd3;
  localparam logic [3:0] SUB_SHL  = 4'd0;
  localparam logic [3:0] SUB_SHR  = 4'd1;
  localparam logic [3:0] SUB_SAR  = 4'd2;
  localparam logic [3:0] SUB_SAL  = 4'd3;
  localparam logic [3:0] SUB_AND  = 4'd0;
  localparam logic [3:0] SUB_OR   = 4'd1;
  localparam logic [3:0] SUB_XOR  = 4'd2;
  localparam logic [3:0] SUB_NOR  = 4'd3;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_C = 0;

  localparam int         MUL_STEPS = 32;
  localparam logic [4:0] MUL_LAST  = 5'(MUL_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_RESP
  } state_t;

  function automatic logic is_illegal(input logic [1:0] unit, input logic [3:0] sub,
                                      input logic [31:0] b);
    is_illegal = 1'b0;
    if (unit != UNIT_MUL && sub > 4'd3) is_illegal = 1'b1;
    if (unit == UNIT_SHIFT && b > 32'd31) is_illegal = 1'b1;
  endfunction

  function automatic logic [3:0] pack_flags(input logic n, input logic z, input logic v,
                                            input logic c);
    pack_flags        = 4'd0;
    pack_flags[FLG_N] = n;
    pack_flags[FLG_Z] = z;
    pack_flags[FLG_V] = v;
    pack_flags[FLG_C] = c;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from req, priority flips on each advance.
// The requester not granted last wins the next contention; RR_FIRST wins the first one.
module rr_arb2 #(
  parameter bit RR_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= RR_FIRST;
    else if (advance) prio_q <= ~gnt[1];
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one combinational ALU between two requesters; multiply runs as a 32-step shift-add on the adder.
// Latency: 2 cycles for ALU ops, 33 for multiply, 1 for illegal; responses hold until rsp_ready.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter bit RR_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [1:0]        r0_unit,
  input  logic [3:0]        r0_sub,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [1:0]        r1_unit,
  input  logic [3:0]        r1_sub,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic [3:0]        alu_op,
  output logic [3:0]        alu_op1,
  output logic [DATA_W-1:0] alu_in0,
  output logic [DATA_W-1:0] alu_in1,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic              alu_zero,
  input  logic              alu_n,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_lo,
  output logic [DATA_W-1:0] rsp_hi,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err
);

  state_t            state_q, state_d;
  logic [1:0]        gnt;
  logic              acc, sel, req_bad;
  logic [1:0]        req_unit;
  logic [3:0]        req_sub;
  logic [DATA_W-1:0] req_a, req_b;

  logic              id_q;
  logic [1:0]        unit_q;
  logic [3:0]        sub_q;
  logic [DATA_W-1:0] a_q;
  // lo_q is operand B for single-cycle ops and the multiplier/low product word during MUL
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_q;
  logic [4:0]        cnt_q;

  logic [DATA_W:0]   msum;
  logic [DATA_W-1:0] mhi, mlo;
  logic              shr_zero;

  rr_arb2 #(.RR_FIRST(RR_FIRST)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({r1_valid, r0_valid}),
    .advance (acc),
    .gnt     (gnt)
  );

  assign sel      = gnt[1];
  assign acc      = (state_q == ST_IDLE) && (gnt != 2'b00);
  assign req_unit = sel ? r1_unit : r0_unit;
  assign req_sub  = sel ? r1_sub  : r0_sub;
  assign req_a    = sel ? r1_a    : r0_a;
  assign req_b    = sel ? r1_b    : r0_b;
  assign req_bad  = is_illegal(req_unit, req_sub, req_b);

  assign msum     = {alu_carry, alu_out};
  assign mhi      = msum[DATA_W:1];
  assign mlo      = {msum[0], lo_q[DATA_W-1:1]};
  // Right shift by zero would make the ALU report carry from bit -1
  assign shr_zero = (unit_q == UNIT_SHIFT) && (sub_q == SUB_SHR || sub_q == SUB_SAR) &&
                    (lo_q == '0);

  assign rsp_valid = (state_q == ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    alu_op   = 4'd0;
    alu_op1  = 4'd0;
    alu_in0  = '0;
    alu_in1  = '0;
    case (state_q)
      ST_IDLE: begin
        r0_ready = gnt[0];
        r1_ready = gnt[1];
        if (acc) begin
          if (req_unit == UNIT_MUL) state_d = ST_MUL;
          else if (req_bad) state_d = ST_RESP;
          else state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op  = {2'b00, unit_q};
        alu_op1 = sub_q;
        alu_in0 = a_q;
        alu_in1 = lo_q;
        state_d = ST_RESP;
      end
      ST_MUL: begin
        alu_in0 = hi_q;
        alu_in1 = lo_q[0] ? a_q : '0;
        if (cnt_q == MUL_LAST) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q      <= 1'b0;
      unit_q    <= 2'd0;
      sub_q     <= 4'd0;
      a_q       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cnt_q     <= 5'd0;
      rsp_id    <= 1'b0;
      rsp_lo    <= '0;
      rsp_hi    <= '0;
      rsp_flags <= 4'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            id_q   <= sel;
            unit_q <= req_unit;
            sub_q  <= req_sub;
            a_q    <= req_a;
            lo_q   <= req_b;
            hi_q   <= '0;
            cnt_q  <= 5'd0;
            if (req_bad && req_unit != UNIT_MUL) begin
              rsp_id    <= sel;
              rsp_lo    <= '0;
              rsp_hi    <= '0;
              rsp_flags <= 4'd0;
              rsp_err   <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          rsp_id  <= id_q;
          rsp_hi  <= '0;
          rsp_err <= 1'b0;
          if (shr_zero) begin
            rsp_lo    <= a_q;
            rsp_flags <= pack_flags(alu_n, alu_zero, alu_ovf, 1'b0);
          end else begin
            rsp_lo    <= alu_out;
            rsp_flags <= pack_flags(alu_n, alu_zero, alu_ovf, alu_carry);
          end
        end
        ST_MUL: begin
          hi_q  <= mhi;
          lo_q  <= mlo;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == MUL_LAST) begin
            rsp_id    <= id_q;
            rsp_hi    <= mhi;
            rsp_lo    <= mlo;
            rsp_err   <= 1'b0;
            rsp_flags <= pack_flags(mhi[DATA_W-1], ({mhi, mlo} == '0), (mhi != '0), 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 32-bit ALU model on the alu_* side.
module tb_alu_issue_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk, rst_n;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [1:0]  r0_unit, r1_unit;
  logic [3:0]  r0_sub, r1_sub;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0]  alu_op, alu_op1;
  logic [31:0] alu_in0, alu_in1, alu_out;
  logic        alu_carry, alu_ovf, alu_zero, alu_n;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_lo, rsp_hi;
  logic [3:0]  rsp_flags;

  int checks = 0;
  int failures = 0;

  alu_issue_ctrl #(.DATA_W(32), .RR_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_unit(r0_unit), .r0_sub(r0_sub),
    .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_unit(r1_unit), .r1_sub(r1_sub),
    .r1_a(r1_a), .r1_b(r1_b),
    .alu_op(alu_op), .alu_op1(alu_op1), .alu_in0(alu_in0), .alu_in1(alu_in1),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
    .alu_n(alu_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_lo(rsp_lo),
    .rsp_hi(rsp_hi), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model; right shifts by zero report carry = 1 to stand in for the undefined bit -1
  logic [31:0] bb;
  logic [32:0] s33;
  always_comb begin
    alu_out = 32'd0; alu_carry = 1'b0; alu_ovf = 1'b0; bb = 32'd0; s33 = 33'd0;
    case (alu_op)
      4'd0: begin
        bb = (alu_op1 == SUB_SUB || alu_op1 == SUB_SUB1) ? ~alu_in1 : alu_in1;
        s33 = {1'b0, alu_in0} + {1'b0, bb} +
              ((alu_op1 == SUB_ADD1 || alu_op1 == SUB_SUB) ? 33'd1 : 33'd0);
        alu_out = s33[31:0];
        alu_carry = s33[32];
        alu_ovf = (alu_in0[31] == bb[31]) && (s33[31] != alu_in0[31]);
      end
      4'd1: begin
        if (alu_op1 == SUB_SHL || alu_op1 == SUB_SAL) begin
          s33 = {1'b0, alu_in0} << alu_in1[4:0];
          alu_out = s33[31:0];
          alu_carry = s33[32];
        end else begin
          if (alu_op1 == SUB_SAR) s33 = 33'($signed({alu_in0, 1'b0}) >>> alu_in1[4:0]);
          else s33 = {alu_in0, 1'b0} >> alu_in1[4:0];
          alu_out = s33[32:1];
          alu_carry = (alu_in1[4:0] == 5'd0) ? 1'b1 : s33[0];
        end
      end
      4'd2: begin
        case (alu_op1)
          SUB_AND: alu_out = alu_in0 & alu_in1;
          SUB_OR:  alu_out = alu_in0 | alu_in1;
          SUB_XOR: alu_out = alu_in0 ^ alu_in1;
          default: alu_out = ~(alu_in0 | alu_in1);
        endcase
      end
      default: alu_out = alu_in0 * alu_in1;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);
  assign alu_n = alu_out[31];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int r, input logic v, input logic [1:0] u, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      r0_valid = v; r0_unit = u; r0_sub = s; r0_a = a; r0_b = b;
    end else begin
      r1_valid = v; r1_unit = u; r1_sub = s; r1_a = a; r1_b = b;
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic do_req(input int r, input logic [1:0] u, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 0;
    drive(r, 1'b1, u, s, a, b);
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if ((r == 0) ? r0_ready : r1_ready) ok = 1;
      @(posedge clk); #1;
    end
    drive(r, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
    if (!ok) chk("req_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input int r, input logic [1:0] u, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic [3:0] exp_flags, input logic exp_err);
    int lat;
    do_req(r, u, s, a, b);
    wait_rsp(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_ctl"}, {rsp_valid, rsp_id, rsp_err, rsp_flags}, {1'b1, 1'(r), exp_err, exp_flags});
    chk({tag, "_lo"}, rsp_lo, exp_lo);
    chk({tag, "_hi"}, rsp_hi, exp_hi);
    take_rsp();
  endtask

  int g_seq[$];
  int id_seq[$];
  int n_acc[2];
  int n_rsp[2];
  int gw, both, seen, lat;

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    drive(0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
    #2;
    chk("rst_ctl", {rsp_valid, r0_ready, r1_ready, rsp_id, rsp_err, rsp_flags, alu_op, alu_op1},
        64'd0);
    chk("rst_alu_in", {alu_in0, alu_in1}, 64'd0);
    chk("rst_rsp_dat", {rsp_hi, rsp_lo}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: both requesters hold 4 adds each
    n_acc[0] = 0; n_acc[1] = 0; n_rsp[0] = 0; n_rsp[1] = 0; both = 0;
    drive(0, 1'b1, UNIT_ADD, SUB_ADD, 32'd0, 32'h100);
    drive(1, 1'b1, UNIT_ADD, SUB_ADD, 32'd0, 32'h200);
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && id_seq.size() < 8; cyc++) begin
      #1;
      if (rsp_valid) begin
        chk($sformatf("arb_rsp%0d_lo", id_seq.size()), rsp_lo,
            (rsp_id ? 32'h200 : 32'h100) + 32'(n_rsp[rsp_id]));
        n_rsp[rsp_id]++;
        id_seq.push_back(int'(rsp_id));
      end
      if (r0_ready && r1_ready) both++;
      gw = r0_ready ? 0 : (r1_ready ? 1 : -1);
      @(posedge clk); #1;
      if (gw >= 0) begin
        g_seq.push_back(gw);
        n_acc[gw]++;
        if (n_acc[gw] == 4) drive(gw, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
        else drive(gw, 1'b1, UNIT_ADD, SUB_ADD, 32'(n_acc[gw]), (gw == 1) ? 32'h200 : 32'h100);
      end
    end
    rsp_ready = 1'b0;
    chk("arb_both_ready", 64'(both), 64'd0);
    chk("arb_grant_count", 64'(g_seq.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("arb_gnt%0d", k), 64'((k < g_seq.size()) ? g_seq[k] : 99), 64'(k % 2));
      chk($sformatf("arb_id%0d", k), 64'((k < id_seq.size()) ? id_seq[k] : 99), 64'(k % 2));
    end

    run_op("add_ovf", 0, UNIT_ADD, SUB_ADD, 32'h7FFFFFFF, 32'd1, 2, 32'h80000000, 32'd0,
           4'b1010, 1'b0);
    run_op("mul_max", 1, UNIT_MUL, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001,
           32'hFFFFFFFE, 4'b1010, 1'b0);
    run_op("mul_zero", 0, UNIT_MUL, 4'd5, 32'd0, 32'd5, 33, 32'd0, 32'd0, 4'b0100, 1'b0);
    run_op("ill_logic", 0, UNIT_LOGIC, 4'd7, 32'h1234, 32'h5678, 1, 32'd0, 32'd0, 4'd0, 1'b1);
    run_op("ill_shift", 1, UNIT_SHIFT, SUB_SHL, 32'h1234, 32'd40, 1, 32'd0, 32'd0, 4'd0, 1'b1);
    run_op("shr_zero", 0, UNIT_SHIFT, SUB_SHR, 32'h80000001, 32'd0, 2, 32'h80000001, 32'd0,
           4'b1000, 1'b0);
    run_op("xor", 1, UNIT_LOGIC, SUB_XOR, 32'hF0F0FFFF, 32'hF0F0FFFF, 2, 32'd0, 32'd0,
           4'b0100, 1'b0);

    // Response stall with a request waiting on r1
    do_req(0, UNIT_ADD, SUB_SUB, 32'd5, 32'd7);
    drive(1, 1'b1, UNIT_ADD, SUB_ADD, 32'd1, 32'd1);
    wait_rsp(lat);
    chk("stall_lat", 64'(lat), 64'd2);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("stall%0d_ctl", i), {rsp_valid, r0_ready, r1_ready, rsp_id, rsp_err, rsp_flags},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000});
      chk($sformatf("stall%0d_dat", i), {rsp_hi, rsp_lo}, {32'd0, 32'hFFFFFFFE});
      @(posedge clk); #1;
    end
    take_rsp();
    #1;
    chk("r1_ready_after_hs", 64'(r1_ready), 64'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
    wait_rsp(lat);
    chk("queued_lat", 64'(lat), 64'd2);
    chk("queued_rsp", {rsp_id, rsp_err, rsp_flags, rsp_lo}, {1'b1, 1'b0, 4'd0, 32'd2});
    take_rsp();

    // Reset in the middle of a multiply
    do_req(0, UNIT_MUL, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (15) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mrst_ctl", {rsp_valid, r0_ready, r1_ready, rsp_id, rsp_err, rsp_flags, alu_op, alu_op1},
        64'd0);
    chk("mrst_alu_in", {alu_in0, alu_in1}, 64'd0);
    chk("mrst_rsp_dat", {rsp_hi, rsp_lo}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    rsp_ready = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    chk("mrst_no_rsp", 64'(seen), 64'd0);
    run_op("add_post_rst", 0, UNIT_ADD, SUB_ADD, 32'd2, 32'd3, 2, 32'd5, 32'd0, 4'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
